// File: rtl/io_bus_pkg.sv
// Shared types and constants for the CPU-to-peripheral bus sequencer.
package io_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_REQ   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } io_bus_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Returned to the CPU on any aborted read so a load never hangs.
    localparam logic [DATA_W-1:0] ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/byte_enable_decoder.sv
// Byte-lane enables and alignment check from access size and address offset.
module byte_enable_decoder
    import io_bus_pkg::*;
(
    input  logic [1:0]      data_type,
    input  logic [1:0]      offset,
    output logic [BE_W-1:0] be,
    output logic            misaligned
);

    // Size code 2'b11 is not a legal access; it enables no lanes.
    always_comb begin
        be         = 4'b0000;
        misaligned = 1'b0;
        case (data_type)
            SIZE_BYTE: be = 4'b0001 << offset;
            SIZE_HALF: begin
                be         = 4'b0011 << offset;
                misaligned = (offset == 2'd3);
            end
            SIZE_WORD: begin
                be         = 4'b1111;
                misaligned = (offset != 2'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/io_bus_controller.sv
// Runs one request/acknowledge bus transaction per CPU load or store strobe,
// with misalignment and timeout aborts.
module io_bus_controller
    import io_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              store,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic [2:0]        data_type,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              busy,
    output logic              bus_error,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [BE_W-1:0]   bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    io_bus_state_t     state;
    io_bus_state_t     state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [DATA_W-1:0] rdata_next;
    logic              rdata_valid_next;
    logic              bus_error_next;
    logic              bus_req_next;
    logic              bus_we_next;
    logic [ADDR_W-1:0] bus_addr_next;
    logic [BE_W-1:0]   bus_be_next;
    logic [DATA_W-1:0] bus_wdata_next;

    logic [BE_W-1:0]   dec_be;
    logic              dec_misaligned;
    logic              unused_bits;

    // Only the size field of funct3 matters; sign-extension is the CPU's job.
    assign unused_bits = data_type[2];

    byte_enable_decoder u_be_dec (
        .data_type  (data_type[1:0]),
        .offset     (address[1:0]),
        .be         (dec_be),
        .misaligned (dec_misaligned)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus next value of every registered output; pulses default low.
    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        rdata_next       = rdata;
        rdata_valid_next = 1'b0;
        bus_error_next   = 1'b0;
        bus_req_next     = bus_req;
        bus_we_next      = bus_we;
        bus_addr_next    = bus_addr;
        bus_be_next      = bus_be;
        bus_wdata_next   = bus_wdata;

        case (state)
            ST_IDLE: begin
                if (store || load) begin
                    bus_we_next   = store;
                    bus_addr_next = {address[ADDR_W-1:2], 2'b00};
                    bus_be_next   = dec_be;
                    if (dec_misaligned) begin
                        state_next     = ST_ERR;
                        bus_error_next = 1'b1;
                        if (!store) begin
                            rdata_next       = ERR_DATA;
                            rdata_valid_next = 1'b1;
                        end
                    end else begin
                        state_next = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                // Store data only becomes valid one cycle after the strobe.
                bus_wdata_next = wdata;
                cnt_next       = '0;
                bus_req_next   = 1'b1;
                state_next     = ST_REQ;
            end
            ST_REQ: begin
                if (bus_ack) begin
                    bus_req_next = 1'b0;
                    state_next   = ST_DONE;
                    if (!bus_we) begin
                        rdata_next       = bus_rdata;
                        rdata_valid_next = 1'b1;
                    end
                end else if (cnt == CNT_MAX) begin
                    bus_req_next   = 1'b0;
                    state_next     = ST_ERR;
                    bus_error_next = 1'b1;
                    if (!bus_we) begin
                        rdata_next       = ERR_DATA;
                        rdata_valid_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_DONE: state_next = ST_IDLE;
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            bus_error   <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_be      <= '0;
            bus_wdata   <= '0;
        end else begin
            cnt         <= cnt_next;
            rdata       <= rdata_next;
            rdata_valid <= rdata_valid_next;
            bus_error   <= bus_error_next;
            bus_req     <= bus_req_next;
            bus_we      <= bus_we_next;
            bus_addr    <= bus_addr_next;
            bus_be      <= bus_be_next;
            bus_wdata   <= bus_wdata_next;
        end
    end

endmodule

// File: tb/tb_io_bus_controller.sv
// Self-checking bench for io_bus_controller: directed scenarios plus randomized
// accesses against a cycle-window reference model.
module tb_io_bus_controller;

    localparam int unsigned T    = 4;
    localparam int          NCYC = 12;

    logic        clock = 1'b0;
    logic        reset;
    logic        store;
    logic        load;
    logic [31:0] address;
    logic [2:0]  data_type;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        busy;
    logic        bus_error;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    // Per-cycle observations (index = cycles after the strobe edge).
    logic        obs_busy  [0:NCYC];
    logic        obs_req   [0:NCYC];
    logic        obs_valid [0:NCYC];
    logic        obs_err   [0:NCYC];
    logic        obs_we    [0:NCYC];
    logic [31:0] obs_addr  [0:NCYC];
    logic [3:0]  obs_be    [0:NCYC];
    logic [31:0] obs_wdata [0:NCYC];
    logic [31:0] obs_rdata [0:NCYC];

    // Reference model expectations.
    logic        exp_busy  [0:NCYC];
    logic        exp_req   [0:NCYC];
    logic        exp_valid [0:NCYC];
    logic        exp_err   [0:NCYC];
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_rd_at_valid;
    logic [31:0] model_rdata;

    io_bus_controller #(.TIMEOUT_CYCLES(T)) dut (
        .clock       (clock),
        .reset       (reset),
        .store       (store),
        .load        (load),
        .address     (address),
        .data_type   (data_type),
        .wdata       (wdata),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .busy        (busy),
        .bus_error   (bus_error),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got running exp finished");
        $fatal(1);
    end

    // Strobe in cycle 0, store data in cycle 1, ack pulse in cycle ack_k.
    task automatic run_access(input logic st, input logic ld, input logic [31:0] addr,
                              input logic [2:0] dt, input logic [31:0] wd,
                              input logic [31:0] rd, input int ack_k, input int extra_ld);
        @(posedge clock); #1;
        store = st; load = ld; address = addr; data_type = dt; wdata = ~wd; bus_ack = 1'b0;
        for (int c = 1; c <= NCYC; c++) begin
            @(posedge clock); #1;
            store = 1'b0;
            load  = (c == extra_ld);
            if (c == 1) wdata = wd;
            if (c == 2) begin
                address   = $urandom;
                data_type = 3'($urandom);
                wdata     = $urandom;
            end
            bus_ack   = (c == ack_k);
            bus_rdata = (c == ack_k) ? rd : $urandom;
            @(negedge clock);
            obs_busy[c]  = busy;      obs_req[c]   = bus_req;
            obs_valid[c] = rdata_valid; obs_err[c] = bus_error;
            obs_we[c]    = bus_we;    obs_addr[c]  = bus_addr;
            obs_be[c]    = bus_be;    obs_wdata[c] = bus_wdata;
            obs_rdata[c] = rdata;
        end
        bus_ack = 1'b0;
        load    = 1'b0;
    endtask

    // A transaction is a window of cycles: aborted at once if it would cross a
    // word, else requesting from cycle 2 until ack or the wait limit runs out.
    task automatic model_access(input logic we, input logic [31:0] addr, input logic [2:0] dt,
                                input logic [31:0] rd, input int ack_k);
        int size;
        int off;
        int last;
        int req_end;
        bit acked;
        size = 1 << dt[1:0];
        off  = int'(addr[1:0]);
        for (int c = 0; c <= NCYC; c++) begin
            exp_busy[c] = 1'b0; exp_req[c] = 1'b0; exp_valid[c] = 1'b0; exp_err[c] = 1'b0;
        end
        exp_addr = addr & 32'hFFFF_FFFC;
        exp_be   = 4'(((1 << size) - 1) << off);
        if (off + size > 4) begin
            last = 1;
            acked = 1'b0;
        end else begin
            acked   = (ack_k >= 2) && (ack_k <= int'(T) + 2);
            req_end = acked ? ack_k : int'(T) + 2;
            for (int c = 2; c <= req_end; c++) exp_req[c] = 1'b1;
            last = req_end + 1;
        end
        for (int c = 1; c <= last; c++) exp_busy[c] = 1'b1;
        if (!acked) exp_err[last] = 1'b1;
        if (!we) begin
            exp_valid[last] = 1'b1;
            model_rdata     = acked ? rd : 32'hFFFF_FFFF;
        end
        exp_rd_at_valid = model_rdata;
    endtask

    task automatic test_reset();
        reset = 1'b1; store = 1'b0; load = 1'b0; address = '0; data_type = '0;
        wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
        #12;
        checks++;
        if ({rdata, rdata_valid, busy, bus_error, bus_req, bus_we} !== 38'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %h exp 0", {rdata, rdata_valid, busy, bus_error, bus_req, bus_we});
        end
        checks++;
        if ({bus_addr, bus_be, bus_wdata} !== 68'd0) begin
            errors++;
            $display("FAIL reset_bus got %h exp 0", {bus_addr, bus_be, bus_wdata});
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_word_store();
        run_access(1'b1, 1'b0, 32'h100, 3'b010, 32'hDEADBEEF, 32'h0, 4, 0);
        for (int c = 1; c <= NCYC; c++) begin
            checks++;
            if ({obs_req[c], obs_busy[c], obs_valid[c], obs_err[c]} !==
                {(c >= 2 && c <= 4), (c <= 5), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL store_timing c=%0d got req/busy/valid/err %b%b%b%b", c,
                         obs_req[c], obs_busy[c], obs_valid[c], obs_err[c]);
            end
        end
        checks++;
        if ({obs_we[3], obs_addr[3], obs_be[3], obs_wdata[3]} !== {1'b1, 32'h100, 4'hF, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL store_bus got we=%b addr=%h be=%b wdata=%h", obs_we[3], obs_addr[3], obs_be[3], obs_wdata[3]);
        end
    endtask

    task automatic test_byte_load();
        run_access(1'b0, 1'b1, 32'h203, 3'b000, 32'h0, 32'h11223344, 2, 0);
        for (int c = 1; c <= NCYC; c++) begin
            checks++;
            if ({obs_req[c], obs_busy[c], obs_valid[c], obs_err[c]} !==
                {(c == 2), (c <= 3), (c == 3), 1'b0}) begin
                errors++;
                $display("FAIL byte_load_timing c=%0d got req/busy/valid/err %b%b%b%b", c,
                         obs_req[c], obs_busy[c], obs_valid[c], obs_err[c]);
            end
        end
        checks++;
        if ({obs_we[2], obs_addr[2], obs_be[2], obs_rdata[3]} !== {1'b0, 32'h200, 4'b1000, 32'h11223344}) begin
            errors++;
            $display("FAIL byte_load_data got we=%b addr=%h be=%b rdata=%h exp 0 200 1000 11223344",
                     obs_we[2], obs_addr[2], obs_be[2], obs_rdata[3]);
        end
    endtask

    task automatic test_misaligned();
        run_access(1'b0, 1'b1, 32'h7, 3'b001, 32'h0, 32'h0, 0, 0);
        for (int c = 1; c <= NCYC; c++) begin
            checks++;
            if ({obs_req[c], obs_busy[c], obs_valid[c], obs_err[c]} !==
                {1'b0, (c == 1), (c == 1), (c == 1)}) begin
                errors++;
                $display("FAIL misaligned_timing c=%0d got req/busy/valid/err %b%b%b%b", c,
                         obs_req[c], obs_busy[c], obs_valid[c], obs_err[c]);
            end
        end
        checks++;
        if (obs_rdata[1] !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL misaligned_rdata got %h exp ffffffff", obs_rdata[1]);
        end
    endtask

    task automatic test_timeout();
        run_access(1'b0, 1'b1, 32'h40, 3'b010, 32'h0, 32'h0, 0, 0);
        for (int c = 1; c <= NCYC; c++) begin
            checks++;
            if ({obs_req[c], obs_busy[c], obs_valid[c], obs_err[c]} !==
                {(c >= 2 && c <= 6), (c <= 7), (c == 7), (c == 7)}) begin
                errors++;
                $display("FAIL timeout_timing c=%0d got req/busy/valid/err %b%b%b%b", c,
                         obs_req[c], obs_busy[c], obs_valid[c], obs_err[c]);
            end
        end
        checks++;
        if (obs_rdata[7] !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL timeout_rdata got %h exp ffffffff", obs_rdata[7]);
        end
    endtask

    task automatic test_ack_at_limit();
        run_access(1'b0, 1'b1, 32'h44, 3'b010, 32'h0, 32'h0000CAFE, 6, 0);
        for (int c = 1; c <= NCYC; c++) begin
            checks++;
            if ({obs_err[c], obs_valid[c]} !== {1'b0, (c == 7)}) begin
                errors++;
                $display("FAIL ack_limit c=%0d got err/valid %b%b", c, obs_err[c], obs_valid[c]);
            end
        end
        checks++;
        if (obs_rdata[7] !== 32'h0000CAFE) begin
            errors++;
            $display("FAIL ack_limit_rdata got %h exp 0000cafe", obs_rdata[7]);
        end
    endtask

    task automatic test_store_load_collision();
        run_access(1'b1, 1'b1, 32'h300, 3'b010, 32'h12345678, 32'h0, 3, 2);
        for (int c = 1; c <= NCYC; c++) begin
            checks++;
            if ({obs_req[c], obs_busy[c], obs_valid[c]} !== {(c >= 2 && c <= 3), (c <= 4), 1'b0}) begin
                errors++;
                $display("FAIL collision_timing c=%0d got req/busy/valid %b%b%b", c,
                         obs_req[c], obs_busy[c], obs_valid[c]);
            end
        end
        checks++;
        if ({obs_we[2], obs_addr[2], obs_wdata[2], obs_rdata[NCYC]} !==
            {1'b1, 32'h300, 32'h12345678, 32'h0000CAFE}) begin
            errors++;
            $display("FAIL collision_bus got we=%b addr=%h wdata=%h rdata=%h", obs_we[2], obs_addr[2],
                     obs_wdata[2], obs_rdata[NCYC]);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clock); #1;
        load = 1'b1; address = 32'h500; data_type = 3'b010;
        @(posedge clock); #1;
        load = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #2;
        checks++;
        if (bus_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre got bus_req=%b exp 1", bus_req);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus_req, busy, rdata} !== 34'd0) begin
            errors++;
            $display("FAIL reset_mid_async got req=%b busy=%b rdata=%h exp 0 0 0", bus_req, busy, rdata);
        end
        @(negedge clock);
        reset = 1'b0;
        run_access(1'b0, 1'b1, 32'h10, 3'b100, 32'h0, 32'hA5A55A5A, 3, 0);
        for (int c = 1; c <= NCYC; c++) begin
            checks++;
            if ({obs_req[c], obs_busy[c], obs_valid[c], obs_err[c]} !==
                {(c >= 2 && c <= 3), (c <= 4), (c == 4), 1'b0}) begin
                errors++;
                $display("FAIL reset_mid_after c=%0d got req/busy/valid/err %b%b%b%b", c,
                         obs_req[c], obs_busy[c], obs_valid[c], obs_err[c]);
            end
        end
        checks++;
        if ({obs_be[2], obs_rdata[4]} !== {4'b0001, 32'hA5A55A5A}) begin
            errors++;
            $display("FAIL reset_mid_data got be=%b rdata=%h exp 0001 a5a55a5a", obs_be[2], obs_rdata[4]);
        end
    endtask

    task automatic test_random();
        logic        st, ld, we;
        logic [31:0] addr, wd, rd;
        logic [2:0]  dt;
        int          ack_k;
        model_rdata = 32'hA5A55A5A;
        for (int n = 0; n < 40; n++) begin
            st    = 1'($urandom);
            ld    = st ? 1'($urandom) : 1'b1;
            we    = st;
            addr  = $urandom;
            dt    = {1'($urandom), 2'($urandom_range(0, 2))};
            wd    = $urandom;
            rd    = $urandom;
            ack_k = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, T + 4));
            model_access(we, addr, dt, rd, ack_k);
            run_access(st, ld, addr, dt, wd, rd, ack_k, 0);
            for (int c = 1; c <= NCYC; c++) begin
                checks++;
                if ({obs_busy[c], obs_req[c], obs_valid[c], obs_err[c]} !==
                    {exp_busy[c], exp_req[c], exp_valid[c], exp_err[c]}) begin
                    errors++;
                    $display("FAIL rand_ctrl n=%0d c=%0d got %b%b%b%b exp %b%b%b%b", n, c,
                             obs_busy[c], obs_req[c], obs_valid[c], obs_err[c],
                             exp_busy[c], exp_req[c], exp_valid[c], exp_err[c]);
                end
                if (exp_req[c]) begin
                    checks++;
                    if ({obs_we[c], obs_addr[c], obs_be[c], obs_wdata[c]} !== {we, exp_addr, exp_be, wd}) begin
                        errors++;
                        $display("FAIL rand_bus n=%0d c=%0d got %b %h %b %h exp %b %h %b %h", n, c,
                                 obs_we[c], obs_addr[c], obs_be[c], obs_wdata[c], we, exp_addr, exp_be, wd);
                    end
                end
                if (exp_valid[c]) begin
                    checks++;
                    if (obs_rdata[c] !== exp_rd_at_valid) begin
                        errors++;
                        $display("FAIL rand_rdata n=%0d c=%0d got %h exp %h", n, c, obs_rdata[c], exp_rd_at_valid);
                    end
                end
            end
            checks++;
            if (obs_rdata[NCYC] !== model_rdata) begin
                errors++;
                $display("FAIL rand_rdata_hold n=%0d got %h exp %h", n, obs_rdata[NCYC], model_rdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_byte_load();
        test_misaligned();
        test_timeout();
        test_ack_at_limit();
        test_store_load_collision();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_bus_controller.md
# io_bus_controller

Sequencer between the CPU's data I/O stage and the external peripheral bus. On a store or load strobe it builds byte enables and a word-aligned address, runs one request/acknowledge transaction on the bus, and returns read data with a one-cycle valid pulse. That pulse drives the data I/O stage's load capture. It holds `busy` high for the whole transaction so the control unit can stall, and aborts with `bus_error` on misalignment or timeout.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: cycles `bus_req` may wait for `bus_ack` before aborting; width of the wait counter is $clog2(TIMEOUT_CYCLES+1).

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- store  in  1  start a write; same strobe the data I/O stage uses to capture store data
- load  in  1  start a read
- address  in  32  byte address of the access
- data_type  in  3  funct3 encoding; [1:0] = 00 byte, 01 half, 10 word
- wdata  in  32  store data from the data I/O stage output register, valid the cycle after `store`
- rdata  out  32  read word to the data I/O stage input
- rdata_valid  out  1  one-cycle pulse; `rdata` is stable while high
- busy  out  1  transaction in progress
- bus_error  out  1  one-cycle pulse on misalignment or timeout
- bus_req  out  1  bus request, held until ack or timeout
- bus_we  out  1  1 = write
- bus_addr  out  32  {address[31:2], 2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  write data
- bus_ack  in  1  peripheral acknowledge, one cycle
- bus_rdata  in  32  read data, sampled on the `bus_ack` cycle

## Operation
- States: IDLE, SETUP, REQ, DONE, ERR.
- IDLE:
  - On `store` or `load`, latch address, we and be, then go to SETUP.
  - If both are asserted, `store` wins and `load` is dropped silently.
  - Strobes arriving in any other state are ignored; the CPU must stall on `busy`.
- Byte enables, with offset = address[1:0]:
  - byte: 4'b0001 << offset
  - half: 4'b0011 << offset
  - word: 4'b1111
- Misalignment: half with offset 3, or word with offset != 0. IDLE goes straight to ERR and no bus cycle is issued.
- SETUP: latch `bus_wdata <= wdata`, because the store data register only becomes valid here. Clear the wait counter, then go to REQ.
- REQ: `bus_req` = 1 and `bus_addr/be/we/wdata` held constant.
  - On `bus_ack`, capture `bus_rdata` into `rdata` (reads only), then go to DONE.
  - Otherwise increment the counter. When the counter == TIMEOUT_CYCLES, go to ERR.
  - If `bus_ack` arrives on the same cycle the counter hits the limit, ack wins.
- DONE: `rdata_valid` = 1 for reads only, then go to IDLE.
- ERR: `bus_error` = 1. For a read, also set `rdata` = 32'hFFFF_FFFF and `rdata_valid` = 1 so the CPU never hangs. Then go to IDLE.
- `busy` = (state != IDLE), decoded combinationally from the state register.
- `rdata` holds its last value until the next read completes or errors.

## Timing
- Reset values: state IDLE; `rdata` 0; `rdata_valid`, `busy`, `bus_error`, `bus_req`, `bus_we` 0; `bus_addr` 0; `bus_be` 0; `bus_wdata` 0; counter 0.
- Reset asserted mid-transaction drops `bus_req` immediately (asynchronous). No ack is awaited.
- Strobe sampled at edge 0. Then:
  - SETUP during cycle 1.
  - `bus_req` high from cycle 2.
  - Ack in cycle k (k >= 2) gives DONE in cycle k+1.
  - Best case: `rdata_valid` in cycle 3, i.e. 3 cycles after the strobe edge.
- Timeout: `bus_req` stays high for TIMEOUT_CYCLES+1 cycles, then ERR.
- Misaligned access: ERR in cycle 1, with `bus_req` never asserted.
- All outputs are registered except `busy`.

## Structure
- Package `io_bus_pkg`:
  - state enum `io_bus_state_t`
  - data size constants (SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10)
  - error data constant 32'hFFFF_FFFF
- Sub-module `byte_enable_decoder`: combinational; inputs data_type[1:0] and offset[1:0], outputs be[3:0] and misaligned.
- Main module: FSM, wait counter, output registers.

## Test plan
- Aligned word store, address 0x100, wdata 0xDEADBEEF, ack in cycle 4 -> bus_addr 0x100, bus_be 4'b1111, bus_wdata 0xDEADBEEF, bus_req cycles 2-4, busy cycles 1-5, no rdata_valid.
- Byte load, address 0x203, bus_rdata 0x11223344 with ack in cycle 2 -> bus_addr 0x200, bus_be 4'b1000, rdata 0x11223344, rdata_valid pulse in cycle 3.
- Half load at address 0x7 -> bus_error pulse in cycle 1, rdata 0xFFFFFFFF with rdata_valid, bus_req never high.
- Read with no ack, TIMEOUT_CYCLES=4 -> bus_req high 5 cycles, then bus_error + rdata_valid with rdata 0xFFFFFFFF, busy falls next cycle.
- Store and load asserted together, then a load strobe while busy -> one write transaction only, both loads ignored.
- Reset asserted while bus_req high -> bus_req, busy, rdata 0 immediately; first transaction after release behaves normally.
